// File: rtl/gfx_pkg.sv
// Shared gfx types and constants: bus word, byte-lane shift and the default boot length.
package gfx_pkg;
  localparam int AXIL_AW      = 32;
  localparam int AXIL_DW      = 32;
  localparam int SUBWORD_BITS = 2;
  localparam int BOOT_WORDS   = 128;

  typedef logic [AXIL_DW-1:0] word;
  typedef logic [AXIL_AW-1:0] addr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } boot_state_e;

  // Byte address of word idx from base; wraps at the bus address width.
  function automatic addr_t word_addr(input addr_t base, input logic [31:0] idx);
    return base + addr_t'(idx << SUBWORD_BITS);
  endfunction
endpackage

// File: rtl/if_axil.sv
// AXI-Lite bundle for the gfx boot path; m is the master view, s the slave view.
interface if_axil;
  import gfx_pkg::*;

  addr_t                awaddr;
  logic                 awvalid;
  logic                 awready;
  word                  wdata;
  logic [AXIL_DW/8-1:0] wstrb;
  logic                 wvalid;
  logic                 wready;
  logic                 bvalid;
  logic                 bready;
  addr_t                araddr;
  logic                 arvalid;
  logic                 arready;
  word                  rdata;
  logic                 rvalid;
  logic                 rready;

  modport m (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bvalid, arready, rdata, rvalid
  );

  modport s (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bvalid, arready, rdata, rvalid
  );
endinterface

// File: rtl/gfx_axil_chan_track.sv
// One AXI-Lite channel: valid set on launch, dropped on its own handshake (no ready->valid path).
// fin = handshake done so far, including a handshake completing this cycle; sticky until next launch.
module gfx_axil_chan_track (
  input  logic clk,
  input  logic rst_n,
  input  logic launch,
  input  logic peer,
  output logic vld,
  output logic fin
);
  logic done_q;
  logic hs;

  assign hs  = vld & peer;
  assign fin = done_q | hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld    <= 1'b0;
      done_q <= 1'b0;
    end else if (launch) begin
      vld    <= 1'b1;
      done_q <= 1'b0;
    end else if (hs) begin
      vld    <= 1'b0;
      done_q <= 1'b1;
    end
  end
endmodule

// File: rtl/gfx_boot_loader.sv
// Copies WORDS words ROM->destination over AXI-Lite, then releases the shader core reset.
// Two cycles per word with zero-wait slaves; each channel waits on its own ready/valid.
module gfx_boot_loader
  import gfx_pkg::*;
#(
  parameter int    WORDS    = BOOT_WORDS,
  parameter addr_t ROM_BASE = '0,
  parameter addr_t DST_BASE = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  if_axil.m    rom,
  if_axil.m    dst,
  output logic busy,
  output logic done,
  output logic core_rst_n
);
  localparam int            IW   = $clog2(WORDS) + 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  boot_state_e   state;
  logic [IW-1:0] idx;
  word           data;
  logic          rd_launch, wr_launch, rd_all, wr_all, last, r_hs;
  logic          ar_fin, r_fin, aw_fin, w_fin, b_fin;

  assign r_hs      = rom.rready & rom.rvalid;
  assign rd_all    = ar_fin & r_fin;
  assign wr_all    = aw_fin & w_fin & b_fin;
  assign last      = (idx == LAST);
  assign rd_launch = ((state == ST_IDLE) && start) || ((state == ST_WRITE) && wr_all && !last);
  assign wr_launch = (state == ST_READ) && rd_all;

  gfx_axil_chan_track u_ar (.clk(clk), .rst_n(rst_n), .launch(rd_launch), .peer(rom.arready), .vld(rom.arvalid), .fin(ar_fin));
  gfx_axil_chan_track u_r  (.clk(clk), .rst_n(rst_n), .launch(rd_launch), .peer(rom.rvalid),  .vld(rom.rready),  .fin(r_fin));
  gfx_axil_chan_track u_aw (.clk(clk), .rst_n(rst_n), .launch(wr_launch), .peer(dst.awready), .vld(dst.awvalid), .fin(aw_fin));
  gfx_axil_chan_track u_w  (.clk(clk), .rst_n(rst_n), .launch(wr_launch), .peer(dst.wready),  .vld(dst.wvalid),  .fin(w_fin));
  gfx_axil_chan_track u_b  (.clk(clk), .rst_n(rst_n), .launch(wr_launch), .peer(dst.bvalid),  .vld(dst.bready),  .fin(b_fin));

  // The ROM port only reads and the destination port only writes.
  assign rom.awaddr  = '0;
  assign rom.awvalid = 1'b0;
  assign rom.wdata   = '0;
  assign rom.wstrb   = '0;
  assign rom.wvalid  = 1'b0;
  assign rom.bready  = 1'b0;
  assign dst.araddr  = '0;
  assign dst.arvalid = 1'b0;
  assign dst.rready  = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      data       <= '0;
      rom.araddr <= '0;
      dst.awaddr <= '0;
      dst.wdata  <= '0;
      dst.wstrb  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      core_rst_n <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          idx        <= '0;
          rom.araddr <= word_addr(ROM_BASE, 32'd0);
          busy       <= 1'b1;
          state      <= ST_READ;
        end
        ST_READ: begin
          if (r_hs) data <= rom.rdata;
          if (rd_all) begin
            dst.awaddr <= word_addr(DST_BASE, 32'(idx));
            // R may complete in the same cycle as the exit, before data is captured.
            dst.wdata  <= r_hs ? rom.rdata : data;
            dst.wstrb  <= '1;
            state      <= ST_WRITE;
          end
        end
        ST_WRITE: if (wr_all) begin
          if (last) begin
            busy  <= 1'b0;
            state <= ST_DONE;
          end else begin
            idx        <= idx + 1'b1;
            rom.araddr <= word_addr(ROM_BASE, 32'(idx) + 32'd1);
            state      <= ST_READ;
          end
        end
        ST_DONE: begin
          core_rst_n <= 1'b1;
          done       <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gfx_boot_loader.sv
// Three loaders (4 words, 128 words on a bootrom-style slave, 1 word) against small AXI-Lite slave models.
module tb_gfx_boot_loader;
  localparam logic [31:0] RB = 32'h0000_1000;
  localparam logic [31:0] DB = 32'h8000_0040;

  logic       clk;
  logic       rst_n;
  logic [2:0] start;
  logic       stall_en;

  int n_chk = 0;
  int n_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rom_val(input int i);
    if (i >= 0 && i < 4) return 32'h1111_1111 * 32'(i + 1);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  function automatic int ridx(input logic [31:0] a);
    return int'((a - RB) >> 2);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int W       = (g == 0) ? 4 : (g == 1) ? 128 : 1;
    localparam bit BOOTROM = (g == 1);

    if_axil rom();
    if_axil dst();
    logic busy, done, core_rst_n;

    gfx_boot_loader #(.WORDS(W), .ROM_BASE(RB), .DST_BASE(DB)) dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .rom(rom), .dst(dst),
      .busy(busy), .done(done), .core_rst_n(core_rst_n)
    );

    logic m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
    logic [31:0] m_araddr, m_awaddr, m_wdata;
    assign m_arvalid = rom.arvalid;
    assign m_rready  = rom.rready;
    assign m_araddr  = rom.araddr;
    assign m_awvalid = dst.awvalid;
    assign m_wvalid  = dst.wvalid;
    assign m_bready  = dst.bready;
    assign m_awaddr  = dst.awaddr;
    assign m_wdata   = dst.wdata;

    // Bootrom-style slave: rdata 3 cycles after AR appears, arready one cycle after the R handshake.
    logic [1:0]  bst, bcnt;
    logic        br_vld, b_ar_rdy;
    logic [31:0] br_dat;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bst <= 2'd0; bcnt <= 2'd0; br_vld <= 1'b0; b_ar_rdy <= 1'b0; br_dat <= '0;
      end else begin
        case (bst)
          2'd0: if (rom.arvalid) begin bst <= 2'd1; bcnt <= 2'd0; end
          2'd1: if (bcnt == 2'd2) begin
                  br_vld <= 1'b1; br_dat <= rom_val(ridx(rom.araddr)); bst <= 2'd2;
                end else bcnt <= bcnt + 2'd1;
          2'd2: if (br_vld && rom.rready) begin br_vld <= 1'b0; b_ar_rdy <= 1'b1; bst <= 2'd3; end
          default: begin b_ar_rdy <= 1'b0; bst <= 2'd0; end
        endcase
      end
    end
    assign rom.arready = BOOTROM ? b_ar_rdy : 1'b1;
    assign rom.rvalid  = BOOTROM ? br_vld : rom.arvalid;
    assign rom.rdata   = BOOTROM ? br_dat : rom_val(ridx(rom.araddr));
    assign rom.awready = 1'b0;
    assign rom.wready  = 1'b0;
    assign rom.bvalid  = 1'b0;
    assign dst.arready = 1'b0;
    assign dst.rvalid  = 1'b0;
    assign dst.rdata   = '0;

    // Destination slave: zero-wait, or independent random 0..5 cycle stalls on AW, W and B.
    logic       aw_rdy, w_rdy, bv, aw_got, w_got;
    logic [2:0] aw_cnt, w_cnt, b_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        aw_rdy <= 1'b0; w_rdy <= 1'b0; bv <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
        aw_cnt <= 3'd2; w_cnt <= 3'd0; b_cnt <= 3'd1;
      end else begin
        if (dst.awvalid && aw_rdy) begin
          aw_rdy <= 1'b0; aw_got <= 1'b1; aw_cnt <= 3'($urandom_range(0, 5));
        end else if (!aw_got && !aw_rdy) begin
          if (aw_cnt == 3'd0) aw_rdy <= 1'b1;
          else if (dst.awvalid) aw_cnt <= aw_cnt - 3'd1;
        end
        if (dst.wvalid && w_rdy) begin
          w_rdy <= 1'b0; w_got <= 1'b1; w_cnt <= 3'($urandom_range(0, 5));
        end else if (!w_got && !w_rdy) begin
          if (w_cnt == 3'd0) w_rdy <= 1'b1;
          else if (dst.wvalid) w_cnt <= w_cnt - 3'd1;
        end
        if (bv && dst.bready) begin
          bv <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 3'($urandom_range(0, 5));
        end else if (aw_got && w_got && !bv) begin
          if (b_cnt == 3'd0) bv <= 1'b1;
          else b_cnt <= b_cnt - 3'd1;
        end
      end
    end
    assign dst.awready = stall_en ? aw_rdy : 1'b1;
    assign dst.wready  = stall_en ? w_rdy : 1'b1;
    assign dst.bvalid  = stall_en ? bv : (dst.awvalid & dst.wvalid);

    logic [31:0] aw_log [128];
    logic [31:0] w_log  [128];
    int aw_n, w_n, b_n, ar_n, r_n;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        aw_n <= 0; w_n <= 0; b_n <= 0; ar_n <= 0; r_n <= 0;
      end else begin
        if (dst.awvalid && dst.awready) begin
          if (aw_n < 128) aw_log[aw_n] <= dst.awaddr;
          aw_n <= aw_n + 1;
        end
        if (dst.wvalid && dst.wready) begin
          if (w_n < 128) w_log[w_n] <= dst.wdata;
          w_n <= w_n + 1;
        end
        if (dst.bvalid && dst.bready) b_n <= b_n + 1;
        if (rom.arvalid && rom.arready) ar_n <= ar_n + 1;
        if (rom.rvalid && rom.rready) r_n <= r_n + 1;
      end
    end

    // Protocol watch: a stalled valid must stay up with stable payload; wstrb full while wvalid.
    int viol = 0;
    logic p_arv = 1'b0, p_arr = 1'b0, p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0;
    logic [31:0] p_araddr = '0, p_awaddr = '0, p_wdata = '0;
    always @(posedge clk) begin
      if (rst_n)
        viol <= viol
          + int'(p_arv && !p_arr && (!rom.arvalid || rom.araddr != p_araddr))
          + int'(p_awv && !p_awr && (!dst.awvalid || dst.awaddr != p_awaddr))
          + int'(p_wv && !p_wr && (!dst.wvalid || dst.wdata != p_wdata))
          + int'(dst.wvalid && dst.wstrb != 4'hF);
      p_arv <= rom.arvalid && rst_n;  p_arr <= rom.arready;  p_araddr <= rom.araddr;
      p_awv <= dst.awvalid && rst_n;  p_awr <= dst.awready;  p_awaddr <= dst.awaddr;
      p_wv  <= dst.wvalid && rst_n;   p_wr  <= dst.wready;   p_wdata  <= dst.wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input int g);
    start[g] = 1'b1;
    @(posedge clk); #1;
    start[g] = 1'b0;
  endtask

  task automatic wait_core0(input int budget, output int t);
    t = 0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      if (u[0].core_rst_n) begin t = c; break; end
    end
  endtask

  task automatic check_writes0();
    chk("ar_count", u[0].ar_n, 4);
    chk("aw_count", u[0].aw_n, 4);
    chk("w_count", u[0].w_n, 4);
    chk("b_count", u[0].b_n, 4);
    for (int i = 0; i < 4; i++) begin
      chk("wr_addr", u[0].aw_log[i], DB + 32'(4 * i));
      chk("wr_data", u[0].w_log[i], rom_val(i));
    end
  endtask

  function automatic logic [7:0] ctl0();
    return {u[0].m_arvalid, u[0].m_rready, u[0].m_awvalid, u[0].m_wvalid,
            u[0].m_bready, u[0].busy, u[0].done, u[0].core_rst_n};
  endfunction

  initial begin
    int t0, t2, found, bad_words;
    start = '0; stall_en = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_ctl", 32'(ctl0()), 32'h0);
    chk("rst_araddr", u[0].m_araddr, 32'h0);
    chk("rst_awaddr", u[0].m_awaddr, 32'h0);
    chk("rst_wdata", u[0].m_wdata, 32'h0);

    // All three loaders start together; extra start pulses land in READ, WRITE and DONE.
    rst_n = 1'b1;
    @(posedge clk); #1;
    start = 3'b111;
    @(posedge clk); #1;
    start = '0;
    chk("start_arvalid", u[0].m_arvalid, 1);
    chk("start_araddr", u[0].m_araddr, RB);
    chk("start_busy", u[0].busy, 1);
    t0 = 0; t2 = 0;
    for (int c = 1; c <= 3000; c++) begin
      start[0] = (c == 2 || c == 3 || c == 12);
      start[1] = (c % 5 == 2) && (c < 400);
      start[2] = (c == 5);
      @(posedge clk); #1;
      if (t0 == 0 && u[0].core_rst_n) t0 = c;
      if (t2 == 0 && u[2].done) t2 = c;
      if (u[1].done && c > 20) break;
    end
    start = 3'b111;
    @(posedge clk); #1;
    start = '0;
    repeat (3) @(posedge clk); #1;
    chk("done_all", {29'd0, u[0].done, u[1].done, u[2].done}, 32'h7);
    chk("core_all", {29'd0, u[0].core_rst_n, u[1].core_rst_n, u[2].core_rst_n}, 32'h7);
    chk("core0_rise", t0, 9);
    chk("one_word_done", t2, 3);
    check_writes0();
    chk("one_ar", u[2].ar_n, 1);
    chk("one_aw", u[2].aw_n, 1);
    chk("one_addr", u[2].aw_log[0], DB);
    chk("one_data", u[2].w_log[0], 32'h1111_1111);
    chk("boot_ar", u[1].ar_n, 128);
    chk("boot_r", u[1].r_n, 128);
    chk("boot_b", u[1].b_n, 128);
    bad_words = 0;
    for (int i = 0; i < 128; i++)
      if (u[1].aw_log[i] !== DB + 32'(4 * i) || u[1].w_log[i] !== rom_val(i)) bad_words++;
    chk("boot_words_bad", bad_words, 0);

    // Random destination stalls.
    rst_n = 1'b0; #3;
    stall_en = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_start(0);
    wait_core0(600, t0);
    chk("stall_finished", {31'd0, t0 != 0}, 32'h1);
    check_writes0();

    // Reset in WRITE of word 2, then a fresh copy.
    rst_n = 1'b0; #3;
    stall_en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_start(0);
    found = 0;
    for (int c = 0; c < 40; c++) begin
      if (u[0].m_awvalid && u[0].m_awaddr == DB + 32'h8) begin found = 1; break; end
      @(posedge clk); #1;
    end
    chk("abort_reached", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ctl", 32'(ctl0()), 32'h0);
    chk("abort_araddr", u[0].m_araddr, 32'h0);
    chk("abort_awaddr", u[0].m_awaddr, 32'h0);
    chk("abort_wdata", u[0].m_wdata, 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_start(0);
    wait_core0(50, t0);
    chk("restart_core_rise", t0, 9);
    check_writes0();

    chk("proto_viol", u[0].viol + u[1].viol + u[2].viol, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/gfx_boot_loader.md
# gfx_boot_loader

Boot sequencer for the gfx subsystem. After reset and a `start` pulse, it copies `WORDS` consecutive 32-bit words out of the boot ROM over an AXI-Lite read-only master port. It writes each word, in order, to a destination memory over an AXI-Lite write-only master port, then releases the shader core from reset. It is the only master on the boot ROM's AXI-Lite slave port. It tolerates slaves that complete the R handshake before AR.

## Interface

Parameters:
- `WORDS`, 128: number of words copied; range 1..2^16.
- `ROM_BASE`, 32'h0000_0000: byte address of the first ROM word.
- `DST_BASE`, 32'h0000_0000: byte address of the first destination word.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `start`  in  1  single-cycle request to begin the copy; honoured only in IDLE.
- `rom`  if_axil.m  —  read master to the boot ROM. AW, W and B channels are tied idle: awvalid=0, wvalid=0, bready=0.
- `dst`  if_axil.m  —  write master to the destination. AR and R channels are tied idle: arvalid=0, rready=0.
- `busy`  out  1  high in READ/WRITE.
- `done`  out  1  high in DONE; sticky until reset.
- `core_rst_n`  out  1  shader core reset; low until DONE.

## Operation

- States: IDLE, READ, WRITE, DONE.
- Word index `idx` is $clog2(WORDS)+1 bits. Addresses are ROM_BASE + (idx << SUBWORD_BITS) and DST_BASE + (idx << SUBWORD_BITS), computed modulo the if_axil address width.
- **IDLE**:
  - On `start`: idx←0, araddr←ROM_BASE, arvalid←1, rready←1, then go to READ.
  - `start` in any other state is ignored.
- **READ**: per-channel done flags `ar_ok` and `r_ok`, both cleared on entry.
  - AR handshake (arvalid&arready): arvalid←0, ar_ok←1.
  - R handshake (rvalid&rready): capture rdata into `data`, rready←0, r_ok←1.
  - The two handshakes may occur in either order or in the same cycle.
  - Once both have completed (including same-cycle completion): awaddr←dst address, wdata←data, awvalid←1, wvalid←1, bready←1, then go to WRITE.
- **WRITE**: flags `aw_ok`, `w_ok`, `b_ok`; each valid/ready is dropped on its own handshake.
  - When all three handshakes have completed:
    - idx==WORDS-1: go to DONE.
    - Otherwise: idx+1, next araddr, arvalid←1, rready←1, then go to READ.
- **DONE**: `core_rst_n`←1, `done`←1. Held until rst_n.
- Byte strobes: wstrb is all ones whenever wvalid is high.
- AXI rules:
  - A raised valid is never dropped before its handshake.
  - Address and data are stable while valid is high.
  - No channel has a combinational ready→valid path.
- Response codes (rresp/bresp) are not checked.

## Timing

- All outputs are registered.
- Reset values: every valid/ready 0, all addresses and data 0, busy=0, done=0, core_rst_n=0, state IDLE.
- `start` sampled at edge N: arvalid is high from N+1.
- With zero-wait slaves:
  - READ lasts 1 cycle and WRITE lasts 1 cycle, giving 2 cycles per word.
  - core_rst_n rises 2·WORDS+1 cycles after the `start` edge.
- Bootrom-style slave (arready one cycle after the rready handshake, 3-cycle read latency):
  - READ lasts ≥5 cycles.
  - arvalid stays high across the R handshake and drops on the cycle after arready.
- A `rst_n` assertion mid-copy aborts immediately:
  - All valids drop asynchronously and core_rst_n is held low.
  - Any partial AXI transaction is abandoned; slaves are reset by the same `rst_n`.

## Structure

- `word` and `SUBWORD_BITS` come from the shared `gfx` package.
- The default boot length constant `BOOT_WORDS` (128) also lives in the `gfx` package, so the ROM depth and the loader stay in sync.
- One sub-module, `gfx_axil_chan_track`, holds a single valid/done flag pair per channel: set on launch, cleared on handshake, done sticky until the next launch. It is instantiated 5 times (AR, R, AW, W, B).

## Test plan

- Zero-wait slaves, WORDS=4, ROM holding 0x11111111..0x44444444:
  - dst receives writes to DST_BASE+0/4/8/C with those values, in order.
  - core_rst_n rises 9 cycles after `start`.
- Bootrom-model slave (arready after R):
  - Each read completes.
  - arvalid is never dropped before arready.
  - No duplicate AR is issued.
  - All 128 words are copied correctly.
- dst with random awready/wready/bready stalls (0–5 cycles, AW before W, W before AW, same cycle):
  - Exactly one write is issued per word.
  - awaddr, wdata and wstrb stay stable under stall.
- `start` pulses during READ, WRITE and DONE:
  - Ignored; no extra transactions.
  - `done` stays 1 once set.
- `rst_n` asserted while in WRITE at idx=2:
  - All outputs return to reset values within the same cycle.
  - A new `start` copies again from idx=0.
- WORDS=1:
  - A single read and a single write occur.
  - DONE is reached 3 cycles after `start`.
